tlk2711_tx_frame_sched: RTL and testbench
=========================================

Name: tlk2711_tx_frame_sched

Overview:
- Sequences TLK2711 tx test frames into the tx FIFO: on a start pulse it emits N frames of the incrementing byte pattern, with a programmable idle gap between frames.
- Frame length is selected by tx mode.
- Sits upstream of the tx FIFO; its output stream is what the tx validation checker consumes downstream.
- Reports busy/done and an error-free frame count to the register block.

Parameters:
- NORM_LEN, 435, words per frame for tx modes other than 3 (870 bytes / 2).
- LONG_LEN, 5376, words per frame for tx mode 3 (10752 bytes / 2).
- GAP_W, 8, width of the inter-frame gap count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_soft_rst  in  1  synchronous active-high soft reset; identical effect to rst.
- i_tx_start  in  1  level; the rising edge starts a run.
- i_tx_stop  in  1  level; requests an early stop at the next frame boundary.
- i_tx_mode  in  3  frame-length select, sampled at start.
- i_frame_num  in  16  frames per run, sampled at start; 0 = continuous until stop.
- i_gap_cycles  in  GAP_W  idle cycles between frames, sampled at start.
- i_ready  in  1  FIFO can accept (i.e. not full).
- o_valid  out  1  data word valid.
- o_data  out  16  pattern word.
- o_sof  out  1  first word of frame, qualified by o_valid.
- o_eof  out  1  last word of frame, qualified by o_valid.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle pulse when a run ends.
- o_frame_cnt  out  16  frames completed in the current or last run.

Behaviour:
- One clock. Reset is synchronous and active-high: `rst` or `i_soft_rst` sampled high at a clk edge resets the block.
- Reset values: o_valid=0, o_data=16'h0001, o_sof=0, o_eof=0, o_busy=0, o_done=0, o_frame_cnt=0, state=IDLE, internal edge register=0.
- Reset mid-run aborts immediately; no partial-frame completion.
- Start edge detection:
  - start_p is registered as (~start_r & i_tx_start).
  - start_p is acted on only in IDLE; edges seen in other states are ignored.
- IDLE:
  - o_busy=0.
  - On start_p: latch len (LONG_LEN if mode==3, else NORM_LEN), frame_num and gap; clear o_frame_cnt; go to SEND.
  - Latency: i_tx_start first sampled high at edge N gives start_p high after edge N+1 and o_valid=1 after edge N+2.
- SEND:
  - o_busy=1 and o_valid=1.
  - Word k of a frame (k = 0..len-1): o_data = {(2k)[7:0], (2k+1)[7:0]}, i.e. 0x0001, 0x0203, 0x0405, …; the 8-bit byte fields wrap modulo 256.
  - o_sof=1 when k==0; o_eof=1 when k==len-1.
  - Handshake: a word transfers when o_valid & i_ready. While i_ready=0, o_data, o_sof and o_eof hold stable.
  - On transfer of the eof word:
    - o_frame_cnt increments, saturating at 16'hFFFF.
    - o_data reloads to 0x0001.
    - End condition (EC): (frame_num!=0 and the incremented count == frame_num) or i_tx_stop==1 in that cycle.
    - EC true: go to DONE.
    - EC false and gap==0: stay in SEND, with the next frame's sof word on the next cycle.
    - EC false and gap!=0: go to GAP.
  - i_tx_stop is never acted on mid-frame; frames are always complete.
- GAP:
  - o_valid=0 and o_busy=1.
  - Counts exactly gap cycles, then returns to SEND.
  - i_tx_stop high during GAP: go to DONE at the end of the gap count.
- DONE:
  - o_done=1 for exactly one cycle, o_busy=0, o_valid=0.
  - Next state is IDLE. o_frame_cnt holds until the next start.
- Counters:
  - The word counter is 13 bits, compared against len-1.
  - The gap counter is GAP_W bits.
  - No other wrap-around is allowed.

Test Plan:
- Single normal frame: mode=0, frame_num=1, gap=0, i_ready=1.
  - Expect exactly 435 words: 0x0001, 0x0203, … word 127 = 0xFEFF, word 128 = 0x0001 (byte wrap).
  - sof on word 0, eof on word 434.
  - o_done pulse one cycle after the eof transfer; o_frame_cnt=1.
- Long mode: mode=3, frame_num=2, gap=4.
  - Expect two 5376-word frames separated by exactly 4 idle cycles; o_frame_cnt=2.
  - Start-to-first-valid latency is 2 cycles.
- Backpressure: toggle i_ready randomly during a mode 0 frame.
  - o_data, o_sof and o_eof stable whenever valid & !ready.
  - Sequence unchanged; no dropped or duplicated words.
- Continuous plus stop: frame_num=0; assert i_tx_stop mid-frame 3.
  - Frame 3 completes fully, then DONE; o_frame_cnt=3.
  - A start edge pulsed during the run is ignored.
- Reset mid-run: assert i_soft_rst at word 200 of frame 1.
  - Next cycle: o_valid=0, o_data=0x0001, o_busy=0, o_frame_cnt=0, no o_done.
  - A new start edge then produces a clean frame from 0x0001.

Source files
------------

// File: rtl/tlk2711_tx_frame_sched_if.sv
// rtl/tlk2711_tx_frame_sched_if.sv - tx frame stream between scheduler and tx FIFO
interface tlk2711_tx_frame_sched_if;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_sof;
  logic        o_eof;
  logic        i_ready;

  modport master (output o_valid, output o_data, output o_sof, output o_eof, input i_ready);
  modport slave  (input o_valid, input o_data, input o_sof, input o_eof, output i_ready);
endinterface

// File: rtl/tlk2711_tx_frame_sched.sv
// rtl/tlk2711_tx_frame_sched.sv - emits N incrementing-byte test frames with idle gaps
module tlk2711_tx_frame_sched #(
  parameter int NORM_LEN = 435,
  parameter int LONG_LEN = 5376,
  parameter int GAP_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_soft_rst,
  input  logic                      i_tx_start,
  input  logic                      i_tx_stop,
  input  logic [2:0]                i_tx_mode,
  input  logic [15:0]               i_frame_num,
  input  logic [GAP_W-1:0]          i_gap_cycles,
  tlk2711_tx_frame_sched_if.master  tx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [15:0]               o_frame_cnt
);

  localparam logic [12:0] NORM_M1 = 13'(NORM_LEN - 1);
  localparam logic [12:0] LONG_M1 = 13'(LONG_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state, state_nxt;
  logic             srst;
  logic             start_s, start_r, start_p;
  logic [12:0]      wcnt, len_m1;
  logic [15:0]      frame_num_r, data_r, cnt_r, cnt_inc;
  logic [GAP_W-1:0] gap_r, gcnt;
  logic             stop_pend;
  logic             xfer, last_word, end_run, gap_end;

  assign srst      = rst | i_soft_rst;
  assign cnt_inc   = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
  assign last_word = (wcnt == len_m1);
  assign xfer      = (state == SEND) && tx.i_ready;
  assign end_run   = ((frame_num_r != 16'd0) && (cnt_inc == frame_num_r)) || i_tx_stop;
  assign gap_end   = (gcnt == gap_r - GAP_W'(1));

  assign tx.o_data   = data_r;
  assign o_frame_cnt = cnt_r;

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx.o_valid = 1'b0;
    tx.o_sof   = 1'b0;
    tx.o_eof   = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        if (start_p) state_nxt = SEND;
      end
      SEND: begin
        tx.o_valid = 1'b1;
        o_busy     = 1'b1;
        tx.o_sof   = (wcnt == 13'd0);
        tx.o_eof   = last_word;
        if (xfer && last_word) begin
          if (end_run)                 state_nxt = DONE;
          else if (gap_r != '0)        state_nxt = GAP;
        end
      end
      GAP: begin
        o_busy = 1'b1;
        if (gap_end) state_nxt = (stop_pend || i_tx_stop) ? DONE : SEND;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The start level is registered once before edge detection, giving a two-cycle start latency.
  always_ff @(posedge clk) begin
    if (srst) begin
      start_s     <= 1'b0;
      start_r     <= 1'b0;
      start_p     <= 1'b0;
      wcnt        <= 13'd0;
      len_m1      <= NORM_M1;
      frame_num_r <= 16'd0;
      data_r      <= 16'h0001;
      cnt_r       <= 16'd0;
      gap_r       <= '0;
      gcnt        <= '0;
      stop_pend   <= 1'b0;
    end else begin
      start_s <= i_tx_start;
      start_r <= start_s;
      start_p <= start_s & ~start_r;
      case (state)
        IDLE: begin
          if (start_p) begin
            len_m1      <= (i_tx_mode == 3'd3) ? LONG_M1 : NORM_M1;
            frame_num_r <= i_frame_num;
            gap_r       <= i_gap_cycles;
            cnt_r       <= 16'd0;
            wcnt        <= 13'd0;
            data_r      <= 16'h0001;
            stop_pend   <= 1'b0;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_word) begin
              wcnt      <= 13'd0;
              data_r    <= 16'h0001;
              cnt_r     <= cnt_inc;
              gcnt      <= '0;
              stop_pend <= 1'b0;
            end else begin
              wcnt   <= wcnt + 13'd1;
              data_r <= {data_r[15:8] + 8'd2, data_r[7:0] + 8'd2};
            end
          end
        end
        GAP: begin
          gcnt <= gcnt + GAP_W'(1);
          if (i_tx_stop) stop_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlk2711_tx_frame_sched.sv
// tb/tb_tlk2711_tx_frame_sched.sv - directed bench for tlk2711_tx_frame_sched
module tb_tlk2711_tx_frame_sched;
  logic        clk = 1'b0;
  logic        rst, i_soft_rst, i_tx_start, i_tx_stop;
  logic [2:0]  i_tx_mode;
  logic [15:0] i_frame_num;
  logic [7:0]  i_gap_cycles;
  logic        o_busy, o_done;
  logic [15:0] o_frame_cnt;
  int          checks = 0;
  int          errors = 0;
  int          idle;
  int          i;

  tlk2711_tx_frame_sched_if tx_if ();

  tlk2711_tx_frame_sched #(.NORM_LEN(435), .LONG_LEN(5376), .GAP_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_soft_rst   (i_soft_rst),
    .i_tx_start   (i_tx_start),
    .i_tx_stop    (i_tx_stop),
    .i_tx_mode    (i_tx_mode),
    .i_frame_num  (i_frame_num),
    .i_gap_cycles (i_gap_cycles),
    .tx           (tx_if),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [2:0] mode, input logic [15:0] fnum, input logic [7:0] gap);
    i_tx_mode    = mode;
    i_frame_num  = fnum;
    i_gap_cycles = gap;
    i_tx_start   = 1'b1;
    tick();
    i_tx_start   = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!tx_if.o_valid && n < 64) begin
      n++;
      tick();
    end
    if (n >= 64) chk({tag, " valid timeout"}, 32'(n), 32'd0);
  endtask

  task automatic recv_frame(input int len, input bit bp, input int stop_k, input string tag);
    int          k = 0;
    int          guard = 0;
    bit          held = 1'b0;
    logic [15:0] hd;
    logic        hs, he;
    logic [15:0] exp_d;
    while (k < len && guard < 4 * len + 64) begin
      if (held) begin
        chk({tag, " hold valid"}, 32'(tx_if.o_valid), 32'd1);
        chk({tag, " hold data"}, 32'(tx_if.o_data), 32'(hd));
        chk({tag, " hold sof"}, 32'(tx_if.o_sof), 32'(hs));
        chk({tag, " hold eof"}, 32'(tx_if.o_eof), 32'(he));
        held = 1'b0;
      end
      if (k == stop_k) i_tx_stop = 1'b1;
      tx_if.i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_if.o_valid && tx_if.i_ready) begin
        exp_d = {8'(2 * k), 8'(2 * k + 1)};
        chk({tag, " data"}, 32'(tx_if.o_data), 32'(exp_d));
        chk({tag, " sof"}, 32'(tx_if.o_sof), 32'(k == 0));
        chk({tag, " eof"}, 32'(tx_if.o_eof), 32'(k == len - 1));
        k++;
      end else if (tx_if.o_valid) begin
        held = 1'b1;
        hd   = tx_if.o_data;
        hs   = tx_if.o_sof;
        he   = tx_if.o_eof;
      end
      guard++;
      tick();
    end
    tx_if.i_ready = 1'b1;
    chk({tag, " words"}, 32'(k), 32'(len));
  endtask

  initial begin
    rst = 1'b1; i_soft_rst = 1'b0; i_tx_start = 1'b0; i_tx_stop = 1'b0;
    i_tx_mode = 3'd0; i_frame_num = 16'd0; i_gap_cycles = 8'd0; tx_if.i_ready = 1'b1;
    tick(); tick();
    chk("rst valid", 32'(tx_if.o_valid), 32'd0);
    chk("rst data", 32'(tx_if.o_data), 32'h0001);
    chk("rst sof", 32'(tx_if.o_sof), 32'd0);
    chk("rst eof", 32'(tx_if.o_eof), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst cnt", 32'(o_frame_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // single normal frame
    start_run(3'd0, 16'd1, 8'd0);
    wait_valid("t1", idle);
    chk("t1 latency", 32'(idle), 32'd2);
    chk("t1 busy", 32'(o_busy), 32'd1);
    recv_frame(435, 1'b0, -1, "t1");
    chk("t1 done", 32'(o_done), 32'd1);
    chk("t1 done busy", 32'(o_busy), 32'd0);
    chk("t1 done valid", 32'(tx_if.o_valid), 32'd0);
    chk("t1 cnt", 32'(o_frame_cnt), 32'd1);
    tick();
    chk("t1 done pulse", 32'(o_done), 32'd0);
    chk("t1 cnt hold", 32'(o_frame_cnt), 32'd1);

    // long mode, two frames, gap 4, explicit latency
    tick();
    start_run(3'd3, 16'd2, 8'd4);
    chk("t2 lat0", 32'(tx_if.o_valid), 32'd0);
    tick();
    chk("t2 lat1", 32'(tx_if.o_valid), 32'd0);
    tick();
    chk("t2 lat2", 32'(tx_if.o_valid), 32'd1);
    chk("t2 cnt cleared", 32'(o_frame_cnt), 32'd0);
    recv_frame(5376, 1'b0, -1, "t2f1");
    chk("t2 gap busy", 32'(o_busy), 32'd1);
    chk("t2 cnt mid", 32'(o_frame_cnt), 32'd1);
    wait_valid("t2 gap", idle);
    chk("t2 gap len", 32'(idle), 32'd4);
    recv_frame(5376, 1'b0, -1, "t2f2");
    chk("t2 done", 32'(o_done), 32'd1);
    chk("t2 cnt", 32'(o_frame_cnt), 32'd2);
    tick();

    // backpressure
    start_run(3'd0, 16'd1, 8'd2);
    wait_valid("t3", idle);
    recv_frame(435, 1'b1, -1, "t3");
    chk("t3 done", 32'(o_done), 32'd1);
    chk("t3 cnt", 32'(o_frame_cnt), 32'd1);
    tick();

    // continuous with stop in frame 3 and an ignored start edge
    start_run(3'd1, 16'd0, 8'd1);
    wait_valid("t4", idle);
    recv_frame(435, 1'b0, -1, "t4f1");
    i_tx_start = 1'b1;
    wait_valid("t4 gap1", idle);
    i_tx_start = 1'b0;
    chk("t4 gap1 len", 32'(idle), 32'd1);
    recv_frame(435, 1'b0, -1, "t4f2");
    wait_valid("t4 gap2", idle);
    recv_frame(435, 1'b0, 100, "t4f3");
    chk("t4 done", 32'(o_done), 32'd1);
    chk("t4 cnt", 32'(o_frame_cnt), 32'd3);
    tick();
    i_tx_stop = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk("t4 idle valid", 32'(tx_if.o_valid), 32'd0);
      chk("t4 idle busy", 32'(o_busy), 32'd0);
      tick();
    end

    // soft reset at word 200
    start_run(3'd0, 16'd1, 8'd0);
    wait_valid("t5", idle);
    for (i = 0; i < 200; i++) tick();
    chk("t5 word200", 32'(tx_if.o_data), 32'h9091);
    i_soft_rst = 1'b1;
    tick();
    i_soft_rst = 1'b0;
    chk("t5 valid", 32'(tx_if.o_valid), 32'd0);
    chk("t5 data", 32'(tx_if.o_data), 32'h0001);
    chk("t5 busy", 32'(o_busy), 32'd0);
    chk("t5 cnt", 32'(o_frame_cnt), 32'd0);
    chk("t5 done", 32'(o_done), 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t5 no done", 32'(o_done), 32'd0);
      chk("t5 stays idle", 32'(tx_if.o_valid), 32'd0);
    end
    start_run(3'd0, 16'd1, 8'd0);
    wait_valid("t5 restart", idle);
    recv_frame(435, 1'b0, -1, "t5f");
    chk("t5 done2", 32'(o_done), 32'd1);
    chk("t5 cnt2", 32'(o_frame_cnt), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
